regfile_debug_arbiter: RTL and testbench

// - Owns the register file's rs-read and write ports; shares them between the MIPS pipeline and the debug unit.
// - Dump: while the pipeline is halted, reads all registers in order and streams each word as bytes to the UART TX path.
// - Debug write: lets the debug unit write a register, with the pipeline write-back stage taking priority.
// - Sits between decode/write-back, the debug unit and the register file.

---
 rtl/regfile_debug_arbiter_pkg.sv | 17 +
 rtl/regfile_debug_arbiter_serializer.sv | 49 ++++
 rtl/regfile_debug_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_debug_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_debug_arbiter_pkg.sv
// Shared types and default sizes for the register-file debug arbiter.
// Holds the dump FSM state encoding used by the top level.
package regfile_dbg_pkg;

    localparam int NUM_REGS       = 32;
    localparam int ADDR_WIDTH     = 5;
    localparam int DATA_WIDTH     = 32;
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_e;

endpackage

// File: rtl/regfile_debug_arbiter_serializer.sv
// Word-to-byte serializer: parallel load, MSB-first byte shift-out with a
// valid/ready handshake and a flag marking the final byte of the word.
module word_byte_serializer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  last_byte,
    output logic                  handshake
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [DATA_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      count_q;
    logic                  valid_q;

    assign tx_data   = shift_q[DATA_WIDTH-1 -: 8];
    assign tx_valid  = valid_q;
    assign last_byte = (count_q == CNT_W'(BYTES - 1));
    assign handshake = valid_q & tx_ready;

    // NOTE: reset is synchronous and active-low; every register here is
    // updated with non-blocking assignments so all of them see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            shift_q <= load_data;
            count_q <= '0;
            valid_q <= 1'b1;
        end else if (handshake) begin
            shift_q <= shift_q << 8;
            count_q <= count_q + CNT_W'(1);
            if (last_byte) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_debug_arbiter.sv
// Shares the register file's rs-read and write ports between the pipeline and
// the debug unit, and streams a big-endian byte dump of all registers to TX.
module regfile_debug_arbiter #(
    parameter int NUM_REGS   = regfile_dbg_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = regfile_dbg_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = regfile_dbg_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_pipe_addr_rs,
    input  logic                  i_pipe_wenable,
    input  logic [ADDR_WIDTH-1:0] i_pipe_addr_rd,
    input  logic [DATA_WIDTH-1:0] i_pipe_data_rd,
    input  logic                  i_dbg_halted,
    input  logic                  i_dbg_wenable,
    input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
    input  logic [DATA_WIDTH-1:0] i_dbg_data,
    output logic                  o_dbg_wack,
    input  logic                  i_dump_start,
    output logic                  o_dump_busy,
    output logic                  o_dump_done,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic [ADDR_WIDTH-1:0] o_rf_addr_rs,
    input  logic [DATA_WIDTH-1:0] i_rf_data_rs,
    output logic                  o_rf_wenable,
    output logic [ADDR_WIDTH-1:0] o_rf_addr_rd,
    output logic [DATA_WIDTH-1:0] o_rf_data_rd
);

    import regfile_dbg_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(NUM_REGS - 1);

    dump_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic                  ser_load;
    logic                  ser_last;
    logic                  ser_handshake;

    word_byte_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .load_data (i_rf_data_rs),
        .tx_ready  (i_tx_ready),
        .tx_data   (o_tx_data),
        .tx_valid  (o_tx_valid),
        .last_byte (ser_last),
        .handshake (ser_handshake)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        ser_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_dump_start && i_dbg_halted) begin
                    state_d = ST_LOAD;
                    index_d = '0;
                end
            end
            ST_LOAD: begin
                ser_load = 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (ser_handshake && ser_last) begin
                    if (index_q == LAST_INDEX) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + ADDR_WIDTH'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_dump_busy = (state_q != ST_IDLE);
    assign o_dump_done = (state_q == ST_DONE);

    // The dump borrows the rs port only for the single LOAD cycle.
    assign o_rf_addr_rs = (state_q == ST_LOAD) ? index_q : i_pipe_addr_rs;

    // Write-back always wins; a refused debug write is simply retried later.
    always_comb begin
        o_rf_wenable = 1'b0;
        o_rf_addr_rd = i_pipe_addr_rd;
        o_rf_data_rd = i_pipe_data_rd;
        o_dbg_wack   = 1'b0;
        if (i_pipe_wenable) begin
            o_rf_wenable = 1'b1;
        end else if (i_dbg_wenable && i_dbg_halted) begin
            o_rf_wenable = 1'b1;
            o_rf_addr_rd = i_dbg_addr;
            o_rf_data_rd = i_dbg_data;
            o_dbg_wack   = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_debug_arbiter.sv
// Self-checking bench for regfile_debug_arbiter: table-driven write arbitration,
// random arbitration against a rule model, and byte-stream dumps vs. expected bytes.
module tb_regfile_debug_arbiter;

    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int BPW = DW / 8;
    localparam int DUMP_CYCLES = NR * (1 + BPW) + 1;
    localparam int BUDGET = 4000;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] i_pipe_addr_rs;
    logic          i_pipe_wenable;
    logic [AW-1:0] i_pipe_addr_rd;
    logic [DW-1:0] i_pipe_data_rd;
    logic          i_dbg_halted;
    logic          i_dbg_wenable;
    logic [AW-1:0] i_dbg_addr;
    logic [DW-1:0] i_dbg_data;
    logic          o_dbg_wack;
    logic          i_dump_start;
    logic          o_dump_busy;
    logic          o_dump_done;
    logic [7:0]    o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_ready;
    logic [AW-1:0] o_rf_addr_rs;
    logic [DW-1:0] i_rf_data_rs;
    logic          o_rf_wenable;
    logic [AW-1:0] o_rf_addr_rd;
    logic [DW-1:0] o_rf_data_rd;

    always #5 clk = ~clk;

    regfile_debug_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_pipe_addr_rs (i_pipe_addr_rs),
        .i_pipe_wenable (i_pipe_wenable),
        .i_pipe_addr_rd (i_pipe_addr_rd),
        .i_pipe_data_rd (i_pipe_data_rd),
        .i_dbg_halted   (i_dbg_halted),
        .i_dbg_wenable  (i_dbg_wenable),
        .i_dbg_addr     (i_dbg_addr),
        .i_dbg_data     (i_dbg_data),
        .o_dbg_wack     (o_dbg_wack),
        .i_dump_start   (i_dump_start),
        .o_dump_busy    (o_dump_busy),
        .o_dump_done    (o_dump_done),
        .o_tx_data      (o_tx_data),
        .o_tx_valid     (o_tx_valid),
        .i_tx_ready     (i_tx_ready),
        .o_rf_addr_rs   (o_rf_addr_rs),
        .i_rf_data_rs   (i_rf_data_rs),
        .o_rf_wenable   (o_rf_wenable),
        .o_rf_addr_rd   (o_rf_addr_rd),
        .o_rf_data_rd   (o_rf_data_rd)
    );

    // Register file model: asynchronous read, synchronous write, bulk seeding.
    logic [DW-1:0] rf      [NR];
    logic [DW-1:0] rf_seed [NR];
    logic          seed_req = 1'b0;

    assign i_rf_data_rs = rf[o_rf_addr_rs];

    always @(posedge clk) begin
        if (seed_req) begin
            for (int i = 0; i < NR; i++) rf[i] <= rf_seed[i];
        end else if (o_rf_wenable) begin
            rf[o_rf_addr_rd] <= o_rf_data_rd;
        end
    end

    int errors = 0;
    int checks = 0;
    logic [7:0] got_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic seed_rf();
        @(negedge clk);
        seed_req = 1'b1;
        @(negedge clk);
        seed_req = 1'b0;
    endtask

    typedef struct {
        logic          pwe;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        logic          dwe;
        logic          halt;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        logic          ewen;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ewack;
    } arb_vec_t;

    arb_vec_t vecs [6];

    task automatic apply_arb(input arb_vec_t v, input string name);
        @(negedge clk);
        i_pipe_wenable = v.pwe;
        i_pipe_addr_rd = v.pa;
        i_pipe_data_rd = v.pd;
        i_dbg_wenable  = v.dwe;
        i_dbg_halted   = v.halt;
        i_dbg_addr     = v.da;
        i_dbg_data     = v.dd;
        #1;
        check({name, " wen"}, 32'(o_rf_wenable), 32'(v.ewen));
        check({name, " wack"}, 32'(o_dbg_wack), 32'(v.ewack));
        if (v.ewen) begin
            check({name, " addr"}, 32'(o_rf_addr_rd), 32'(v.ea));
            check({name, " data"}, o_rf_data_rd, v.ed);
        end
    endtask

    // Priority rules stated directly: write-back first, then a halted debug write.
    function automatic arb_vec_t arb_model(input arb_vec_t v);
        arb_vec_t r = v;
        r.ewen = 1'b0; r.ea = '0; r.ed = '0; r.ewack = 1'b0;
        if (v.pwe) begin
            r.ewen = 1'b1; r.ea = v.pa; r.ed = v.pd;
        end else if (v.dwe && v.halt) begin
            r.ewen = 1'b1; r.ea = v.da; r.ed = v.dd; r.ewack = 1'b1;
        end
        return r;
    endfunction

    task automatic idle_writes();
        @(negedge clk);
        i_pipe_wenable = 1'b0;
        i_dbg_wenable  = 1'b0;
    endtask

    // mode 0: ready held high, 1: random ready, 2: a 5-cycle stall mid-word.
    task automatic run_dump(input int mode, input int restart_at, input string tag);
        logic [7:0] exp_q [$];
        int   cyc, done_cnt, hs, stall_left;
        logic prev_valid, prev_ready;
        logic [7:0] prev_data;
        got_q.delete();
        for (int r = 0; r < NR; r++)
            for (int b = 0; b < BPW; b++)
                exp_q.push_back(8'(rf[r] >> (8 * (BPW - 1 - b))));
        i_pipe_addr_rs = 5'd7;
        i_tx_ready     = 1'b1;
        @(negedge clk);
        i_dbg_halted = 1'b1;
        i_dump_start = 1'b1;
        @(negedge clk);
        i_dump_start = 1'b0;
        check({tag, " load busy"}, 32'(o_dump_busy), 32'd1);
        check({tag, " load no valid"}, 32'(o_tx_valid), 32'd0);
        check({tag, " load rs addr"}, 32'(o_rf_addr_rs), 32'd0);
        prev_valid = 1'b0; prev_ready = 1'b1; prev_data = '0;
        cyc = 0; hs = 0; stall_left = 5; done_cnt = 0;
        while (o_dump_busy && cyc < BUDGET) begin
            case (mode)
                1: i_tx_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (hs == 14 && stall_left > 0) begin
                        i_tx_ready = 1'b0;
                        stall_left--;
                    end else begin
                        i_tx_ready = 1'b1;
                    end
                end
                default: i_tx_ready = 1'b1;
            endcase
            if (prev_valid && !prev_ready) begin
                check({tag, " hold valid"}, 32'(o_tx_valid), 32'd1);
                check({tag, " hold data"}, 32'(o_tx_data), 32'(prev_data));
            end
            if (o_dump_done) done_cnt++;
            if (o_tx_valid && i_tx_ready) begin
                got_q.push_back(o_tx_data);
                hs++;
            end
            i_dump_start = (cyc == restart_at);
            prev_valid = o_tx_valid;
            prev_ready = i_tx_ready;
            prev_data  = o_tx_data;
            @(negedge clk);
            cyc++;
        end
        i_dump_start = 1'b0;
        i_tx_ready   = 1'b1;
        check({tag, " finished in budget"}, 32'(cyc < BUDGET), 32'd1);
        if (mode == 0) check({tag, " busy cycles"}, 32'(cyc), 32'(DUMP_CYCLES));
        check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
        check({tag, " byte count"}, 32'(got_q.size()), 32'(NR * BPW));
        for (int i = 0; i < NR * BPW && i < got_q.size(); i++)
            check($sformatf("%s byte %0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, " idle valid"}, 32'(o_tx_valid), 32'd0);
        check({tag, " idle done"}, 32'(o_dump_done), 32'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        i_pipe_addr_rs = '0; i_pipe_wenable = 1'b0; i_pipe_addr_rd = '0; i_pipe_data_rd = '0;
        i_dbg_halted = 1'b0; i_dbg_wenable = 1'b0; i_dbg_addr = '0; i_dbg_data = '0;
        i_dump_start = 1'b0; i_tx_ready = 1'b1;
        for (int i = 0; i < NR; i++) rf_seed[i] = '0;
        repeat (3) @(negedge clk);
        check("reset valid", 32'(o_tx_valid), 32'd0);
        check("reset data", 32'(o_tx_data), 32'd0);
        check("reset busy", 32'(o_dump_busy), 32'd0);
        check("reset done", 32'(o_dump_done), 32'd0);
        rst = 1'b1;
        seed_rf();

        // Write-port arbitration table
        vecs[0] = '{1'b1, 5'd5, 32'hAAAA0000, 1'b0, 1'b0, 5'd6, 32'h12345678, 1'b1, 5'd5, 32'hAAAA0000, 1'b0};
        vecs[1] = '{1'b1, 5'd5, 32'hAAAA0000, 1'b1, 1'b1, 5'd6, 32'h12345678, 1'b1, 5'd5, 32'hAAAA0000, 1'b0};
        vecs[2] = '{1'b0, 5'd5, 32'hAAAA0000, 1'b1, 1'b1, 5'd6, 32'h12345678, 1'b1, 5'd6, 32'h12345678, 1'b1};
        vecs[3] = '{1'b0, 5'd5, 32'hAAAA0000, 1'b1, 1'b0, 5'd6, 32'h12345678, 1'b0, 5'd0, 32'h0, 1'b0};
        vecs[4] = '{1'b0, 5'd9, 32'h0BADF00D, 1'b0, 1'b1, 5'd3, 32'hCAFEF00D, 1'b0, 5'd0, 32'h0, 1'b0};
        vecs[5] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd1, 32'h00000001, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0};
        for (int i = 0; i < 6; i++) apply_arb(vecs[i], $sformatf("arb vec %0d", i));

        // Random arbitration against the rule model, plus rs read passthrough while idle
        for (int i = 0; i < 40; i++) begin
            arb_vec_t v;
            v.pwe  = 1'($urandom_range(0, 1));
            v.pa   = AW'($urandom);
            v.pd   = $urandom;
            v.dwe  = 1'($urandom_range(0, 1));
            v.halt = 1'($urandom_range(0, 1));
            v.da   = AW'($urandom);
            v.dd   = $urandom;
            i_pipe_addr_rs = AW'($urandom);
            apply_arb(arb_model(v), $sformatf("arb rand %0d", i));
            check("idle rs passthrough", 32'(o_rf_addr_rs), 32'(i_pipe_addr_rs));
        end
        idle_writes();

        // Pipe and debug writes collide; then the debug write alone is accepted
        rf_seed[5] = '0; rf_seed[6] = '0;
        seed_rf();
        @(negedge clk);
        i_pipe_wenable = 1'b1; i_pipe_addr_rd = 5'd5; i_pipe_data_rd = 32'hAAAA0000;
        i_dbg_wenable = 1'b1; i_dbg_halted = 1'b1; i_dbg_addr = 5'd6; i_dbg_data = 32'h12345678;
        #1;
        check("collide wack", 32'(o_dbg_wack), 32'd0);
        @(negedge clk);
        check("collide reg5", rf[5], 32'hAAAA0000);
        check("collide reg6 untouched", rf[6], 32'h0);
        i_pipe_wenable = 1'b0;
        #1;
        check("retry wack", 32'(o_dbg_wack), 32'd1);
        @(negedge clk);
        check("retry reg6", rf[6], 32'h12345678);
        i_dbg_halted = 1'b0;
        #1;
        check("unhalted dbg wack", 32'(o_dbg_wack), 32'd0);
        check("unhalted dbg wen", 32'(o_rf_wenable), 32'd0);
        idle_writes();

        // Start while not halted is ignored
        @(negedge clk);
        i_dbg_halted = 1'b0;
        i_dump_start = 1'b1;
        @(negedge clk);
        i_dump_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("unhalted start busy", 32'(o_dump_busy), 32'd0);
            check("unhalted start valid", 32'(o_tx_valid), 32'd0);
            @(negedge clk);
        end

        // Reference dump with a restart pulse mid-dump
        for (int i = 0; i < NR; i++) rf_seed[i] = '0;
        rf_seed[1]  = 32'h11223344;
        rf_seed[31] = 32'hDEADBEEF;
        seed_rf();
        run_dump(0, 20, "ref dump");
        if (got_q.size() == NR * BPW) begin
            check("ref byte4", 32'(got_q[4]), 32'h11);
            check("ref byte7", 32'(got_q[7]), 32'h44);
            check("ref byte124", 32'(got_q[124]), 32'hDE);
            check("ref byte127", 32'(got_q[127]), 32'hEF);
        end else begin
            check("ref stream length", 32'(got_q.size()), 32'(NR * BPW));
        end

        // Backpressure stall and random ready on random contents
        for (int i = 0; i < NR; i++) rf_seed[i] = $urandom;
        seed_rf();
        run_dump(2, -1, "stall dump");
        for (int i = 0; i < NR; i++) rf_seed[i] = $urandom;
        seed_rf();
        run_dump(1, 7, "random ready dump");

        // Reset during SEND of reg 10 aborts, then a new dump starts at reg 0
        begin
            int hs = 0;
            int cyc = 0;
            i_pipe_addr_rs = 5'd7;
            @(negedge clk);
            i_dbg_halted = 1'b1; i_dump_start = 1'b1; i_tx_ready = 1'b1;
            @(negedge clk);
            i_dump_start = 1'b0;
            while (hs < 41 && cyc < BUDGET) begin
                if (o_tx_valid && i_tx_ready) hs++;
                @(negedge clk);
                cyc++;
            end
            check("abort reached reg10", 32'(hs), 32'd41);
            check("abort valid before reset", 32'(o_tx_valid), 32'd1);
            rst = 1'b0;
            @(negedge clk);
            check("abort valid", 32'(o_tx_valid), 32'd0);
            check("abort busy", 32'(o_dump_busy), 32'd0);
            check("abort done", 32'(o_dump_done), 32'd0);
            rst = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("post abort done", 32'(o_dump_done), 32'd0);
                check("post abort busy", 32'(o_dump_busy), 32'd0);
            end
        end
        run_dump(0, -1, "post abort dump");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
